// File: rtl/touch_pkg.sv
// Shared types and helpers for the touch event filter: FSM states, pixel-port width
// and ADC-to-pixel scaling.
package touch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DEB_ON  = 2'd1,
        PRESSED = 2'd2,
        DEB_OFF = 2'd3
    } touch_state_e;

    function automatic int pix_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (v * scr) >> adc_w, truncated; v < 2^adc_w keeps the result below scr.
    function automatic logic [31:0] scale_px(input logic [31:0] v, input int adc_w, input int scr);
        logic [63:0] prod;
        logic [63:0] shifted;
        prod    = {32'd0, v} * 64'(scr);
        shifted = prod >> adc_w;
        return shifted[31:0];
    endfunction

endpackage

// File: rtl/touch_debounce.sv
// Touch-level synchroniser, debounce FSM and one-cycle press/release pulses.
// A level change is accepted once the synced input has held the new value for DEBOUNCE_CYCLES cycles.
module touch_debounce
    import touch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic touch_i,
    output logic touching_o,
    output logic press_o,
    output logic release_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    touch_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= touch_i;
            sync_q <= meta_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // The counter only runs while a candidate level is being held; any bounce restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (sync_q) state_d = DEB_ON;
            end
            DEB_ON: begin
                if (!sync_q)               state_d = IDLE;
                else if (cnt_q == CNT_LAST) state_d = PRESSED;
                else                        cnt_d   = cnt_q + CW'(1);
            end
            PRESSED: begin
                if (!sync_q) state_d = DEB_OFF;
            end
            DEB_OFF: begin
                if (sync_q)                 state_d = PRESSED;
                else if (cnt_q == CNT_LAST) state_d = IDLE;
                else                        cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        touching_o = (state_q == PRESSED) || (state_q == DEB_OFF);
        press_d    = (state_q == DEB_ON)  && (state_d == PRESSED);
        release_d  = (state_q == DEB_OFF) && (state_d == IDLE);
    end

    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/touch_event_filter.sv
// Debounced touch events, saturating press counter and window-averaged coordinates
// scaled into LCD pixel space.
module touch_event_filter
    import touch_pkg::*;
#(
    parameter int ADC_W           = 12,
    parameter int SCR_W           = 800,
    parameter int SCR_H           = 480,
    parameter int AVG_LOG2        = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 10,
    parameter int INVERT_X        = 1,
    parameter int INVERT_Y        = 1
) (
    input  logic                      iCLK,
    input  logic                      iRST_n,
    input  logic                      iTOUCH,
    input  logic                      iSAMPLE,
    input  logic [ADC_W-1:0]          iX_COORD,
    input  logic [ADC_W-1:0]          iY_COORD,
    input  logic                      iCLR_COUNT,
    output logic                      oTOUCHING,
    output logic                      oPRESS,
    output logic                      oRELEASE,
    output logic                      oVALID,
    output logic [pix_w(SCR_W)-1:0]   oX_SCR,
    output logic [pix_w(SCR_H)-1:0]   oY_SCR,
    output logic [CNT_W-1:0]          oPRESS_COUNT
);

    localparam int XW = pix_w(SCR_W);
    localparam int YW = pix_w(SCR_H);
    localparam int AW = ADC_W + AVG_LOG2;
    localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [NW-1:0]    WIN_LAST = NW'((1 << AVG_LOG2) - 1);
    localparam logic [ADC_W-1:0] FULL     = '1;

    logic touching;
    logic press;
    logic release_ev;

    touch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i      (iCLK),
        .rst_ni     (iRST_n),
        .touch_i    (iTOUCH),
        .touching_o (touching),
        .press_o    (press),
        .release_o  (release_ev)
    );

    logic             samp_q;
    logic             rise;
    logic             vld_p0_q, vld_p0_d;
    logic [ADC_W-1:0] x_p0_q, x_p0_d;
    logic [ADC_W-1:0] y_p0_q, y_p0_d;
    logic [AW-1:0]    acc_x_q, acc_x_d;
    logic [AW-1:0]    acc_y_q, acc_y_d;
    logic [NW-1:0]    win_q, win_d;
    logic             vld_p1_q, vld_p1_d;
    logic [ADC_W-1:0] mx_p1_q, mx_p1_d;
    logic [ADC_W-1:0] my_p1_q, my_p1_d;
    logic             valid_q, valid_d;
    logic [XW-1:0]    x_scr_q, x_scr_d;
    logic [YW-1:0]    y_scr_q, y_scr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    sum_x, sum_y;
    logic [ADC_W-1:0] mean_x, mean_y;
    logic [ADC_W-1:0] vx, vy;

    assign rise = iSAMPLE & ~samp_q;

    // Stage p0: capture coordinates on the strobe edge, only while a touch is held.
    always_comb begin
        vld_p0_d = rise & touching;
        x_p0_d   = rise ? iX_COORD : x_p0_q;
        y_p0_d   = rise ? iY_COORD : y_p0_q;
    end

    assign sum_x  = acc_x_q + AW'(x_p0_q);
    assign sum_y  = acc_y_q + AW'(y_p0_q);
    assign mean_x = ADC_W'(sum_x >> AVG_LOG2);
    assign mean_y = ADC_W'(sum_y >> AVG_LOG2);
    assign vx     = (INVERT_X != 0) ? (FULL - mean_x) : mean_x;
    assign vy     = (INVERT_Y != 0) ? (FULL - mean_y) : mean_y;

    // Stage p1: accumulate; leaving the touched states drops any partial window.
    always_comb begin
        acc_x_d  = acc_x_q;
        acc_y_d  = acc_y_q;
        win_d    = win_q;
        vld_p1_d = 1'b0;
        mx_p1_d  = mx_p1_q;
        my_p1_d  = my_p1_q;
        if (!touching) begin
            acc_x_d = '0;
            acc_y_d = '0;
            win_d   = '0;
        end else if (vld_p0_q) begin
            if (win_q == WIN_LAST) begin
                acc_x_d  = '0;
                acc_y_d  = '0;
                win_d    = '0;
                vld_p1_d = 1'b1;
                mx_p1_d  = vx;
                my_p1_d  = vy;
            end else begin
                acc_x_d = sum_x;
                acc_y_d = sum_y;
                win_d   = win_q + NW'(1);
            end
        end
    end

    // Stage p2: registered scale into pixel space; an in-flight result always completes.
    always_comb begin
        valid_d = vld_p1_q;
        x_scr_d = vld_p1_q ? XW'(scale_px(32'(mx_p1_q), ADC_W, SCR_W)) : x_scr_q;
        y_scr_d = vld_p1_q ? YW'(scale_px(32'(my_p1_q), ADC_W, SCR_H)) : y_scr_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (iCLR_COUNT)              cnt_d = '0;
        else if (press && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            samp_q   <= 1'b0;
            vld_p0_q <= 1'b0;
            x_p0_q   <= '0;
            y_p0_q   <= '0;
            acc_x_q  <= '0;
            acc_y_q  <= '0;
            win_q    <= '0;
            vld_p1_q <= 1'b0;
            mx_p1_q  <= '0;
            my_p1_q  <= '0;
            valid_q  <= 1'b0;
            x_scr_q  <= '0;
            y_scr_q  <= '0;
            cnt_q    <= '0;
        end else begin
            samp_q   <= iSAMPLE;
            vld_p0_q <= vld_p0_d;
            x_p0_q   <= x_p0_d;
            y_p0_q   <= y_p0_d;
            acc_x_q  <= acc_x_d;
            acc_y_q  <= acc_y_d;
            win_q    <= win_d;
            vld_p1_q <= vld_p1_d;
            mx_p1_q  <= mx_p1_d;
            my_p1_q  <= my_p1_d;
            valid_q  <= valid_d;
            x_scr_q  <= x_scr_d;
            y_scr_q  <= y_scr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign oTOUCHING    = touching;
    assign oPRESS       = press;
    assign oRELEASE     = release_ev;
    assign oVALID       = valid_q;
    assign oX_SCR       = x_scr_q;
    assign oY_SCR       = y_scr_q;
    assign oPRESS_COUNT = cnt_q;

endmodule

// File: tb/tb_touch_event_filter.sv
// Directed bench for touch_event_filter with a cycle-level behavioural model.
module tb_touch_event_filter;

    localparam int D    = 4;
    localparam int NWIN = 4;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b1;
    logic        iTOUCH = 1'b0;
    logic        iSAMPLE = 1'b0;
    logic [11:0] iX_COORD = '0;
    logic [11:0] iY_COORD = '0;
    logic        iCLR_COUNT = 1'b0;
    logic        oTOUCHING, oPRESS, oRELEASE, oVALID;
    logic [9:0]  oX_SCR;
    logic [8:0]  oY_SCR;
    logic [9:0]  oPRESS_COUNT;

    touch_event_filter #(
        .DEBOUNCE_CYCLES (D),
        .AVG_LOG2        (2)
    ) dut (
        .iCLK         (iCLK),
        .iRST_n       (iRST_n),
        .iTOUCH       (iTOUCH),
        .iSAMPLE      (iSAMPLE),
        .iX_COORD     (iX_COORD),
        .iY_COORD     (iY_COORD),
        .iCLR_COUNT   (iCLR_COUNT),
        .oTOUCHING    (oTOUCHING),
        .oPRESS       (oPRESS),
        .oRELEASE     (oRELEASE),
        .oVALID       (oVALID),
        .oX_SCR       (oX_SCR),
        .oY_SCR       (oY_SCR),
        .oPRESS_COUNT (oPRESS_COUNT)
    );

    always #5 iCLK = ~iCLK;

    int n_total = 0;
    int n_bad   = 0;
    int n_press_obs = 0;
    int n_rel_obs   = 0;
    int n_valid_obs = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: debounced level flips after D+1 consecutive synced samples
    // disagreeing with it (the detection cycle plus D held cycles); windows are plain queues.
    bit s1 = 0, s2 = 0, lvl = 0, prev_samp = 0;
    int run = 0;
    bit e_press = 0, e_rel = 0, e_valid = 0;
    int e_cnt = 0, e_x = 0, e_y = 0;
    bit p_v = 0, o_v = 0;
    int p_x = 0, p_y = 0, o_x = 0, o_y = 0;
    int wx[$];
    int wy[$];

    function automatic int pix(input int sum, input int scr);
        int mean;
        mean = sum / NWIN;
        return ((4095 - mean) * scr) / 4096;
    endfunction

    initial begin
        forever begin
            @(posedge iCLK or negedge iRST_n);
            if (!iRST_n) begin
                s1 = 0; s2 = 0; lvl = 0; prev_samp = 0; run = 0;
                e_press = 0; e_rel = 0; e_valid = 0; e_cnt = 0; e_x = 0; e_y = 0;
                p_v = 0; o_v = 0;
                wx.delete(); wy.delete();
            end else begin
                int sx, sy;
                e_valid = o_v;
                if (o_v) begin e_x = o_x; e_y = o_y; end
                o_v = 0;
                if (!lvl) begin
                    wx.delete(); wy.delete();
                end else if (p_v) begin
                    wx.push_back(p_x); wy.push_back(p_y);
                    if (wx.size() == NWIN) begin
                        sx = 0; sy = 0;
                        foreach (wx[i]) begin sx += wx[i]; sy += wy[i]; end
                        o_v = 1; o_x = pix(sx, 800); o_y = pix(sy, 480);
                        wx.delete(); wy.delete();
                    end
                end
                p_v = iSAMPLE && !prev_samp && lvl;
                p_x = int'(iX_COORD); p_y = int'(iY_COORD);
                prev_samp = iSAMPLE;
                if (iCLR_COUNT) e_cnt = 0;
                else if (e_press && e_cnt < 1023) e_cnt++;
                e_press = 0; e_rel = 0;
                if (s2 != lvl) begin
                    run++;
                    if (run == D + 1) begin
                        lvl = s2; run = 0;
                        e_press = s2; e_rel = !s2;
                    end
                end else begin
                    run = 0;
                end
                s2 = s1; s1 = iTOUCH;
            end
        end
    end

    initial begin
        forever begin
            @(negedge iCLK);
            chk("touching", oTOUCHING, lvl);
            chk("press", oPRESS, e_press);
            chk("release", oRELEASE, e_rel);
            chk("valid", oVALID, e_valid);
            chk("count", oPRESS_COUNT, e_cnt);
            chk("x_scr", oX_SCR, e_x);
            chk("y_scr", oY_SCR, e_y);
            if (oPRESS)   n_press_obs++;
            if (oRELEASE) n_rel_obs++;
            if (oVALID)   n_valid_obs++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic strobe(input int x, input int y, input int hold);
        iX_COORD = 12'(x); iY_COORD = 12'(y); iSAMPLE = 1'b1;
        cyc(hold);
        iSAMPLE = 1'b0;
        cyc(2);
    endtask

    initial begin
        bit seen;
        #1 iRST_n = 1'b0;
        cyc(3);
        chk("reset_touching", oTOUCHING, 0);
        chk("reset_count", oPRESS_COUNT, 0);
        chk("reset_x", oX_SCR, 0);
        iRST_n = 1'b1;
        cyc(2);

        // Glitch high for 3 cycles: rejected.
        iTOUCH = 1'b1; cyc(3); iTOUCH = 1'b0; cyc(10);
        chk("glitch_no_press", n_press_obs, 0);
        chk("glitch_count", oPRESS_COUNT, 0);

        // Real press.
        iTOUCH = 1'b1; cyc(12);
        chk("press_pulses", n_press_obs, 1);
        chk("press_touching", oTOUCHING, 1);
        chk("press_count", oPRESS_COUNT, 1);

        // Glitch low for 2 cycles while pressed: ignored.
        iTOUCH = 1'b0; cyc(2); iTOUCH = 1'b1; cyc(10);
        chk("glitchlow_no_release", n_rel_obs, 0);
        chk("glitchlow_no_press", n_press_obs, 1);

        // Corner window: X=0, Y=4095 with exact 3-cycle latency.
        repeat (3) strobe(0, 4095, 1);
        iX_COORD = 12'd0; iY_COORD = 12'd4095; iSAMPLE = 1'b1;
        cyc(1); iSAMPLE = 1'b0;
        cyc(1);
        chk("lat_not_early", oVALID, 0);
        cyc(1);
        chk("lat_valid", oVALID, 1);
        chk("corner_x", oX_SCR, 799);
        chk("corner_y", oY_SCR, 0);
        cyc(3);

        // Mid-scale window, first strobe held 5 cycles.
        strobe(2048, 2048, 5);
        repeat (3) strobe(2048, 2048, 1);
        cyc(6);
        chk("mid_x", oX_SCR, 399);
        chk("mid_y", oY_SCR, 239);
        chk("mid_valid_cnt", n_valid_obs, 2);

        // Partial window discarded on release.
        repeat (2) strobe(100, 100, 1);
        iTOUCH = 1'b0; cyc(12);
        chk("release_pulses", n_rel_obs, 1);
        chk("partial_no_valid", n_valid_obs, 2);
        iTOUCH = 1'b1; cyc(12);
        repeat (4) strobe(4095, 0, 1);
        cyc(6);
        chk("restart_x", oX_SCR, 0);
        chk("restart_y", oY_SCR, 479);
        chk("restart_valid_cnt", n_valid_obs, 3);
        iTOUCH = 1'b0; cyc(12);

        // Counter saturation.
        repeat (1030) begin
            iTOUCH = 1'b1; cyc(8);
            iTOUCH = 1'b0; cyc(8);
        end
        chk("saturate", oPRESS_COUNT, 1023);

        // Clear coincident with a press pulse.
        iTOUCH = 1'b1;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cyc(1);
            if (oPRESS) seen = 1;
        end
        chk("clr_press_seen", seen, 1);
        iCLR_COUNT = 1'b1; cyc(1); iCLR_COUNT = 1'b0;
        chk("clr_wins", oPRESS_COUNT, 0);
        cyc(3);
        chk("clr_hold", oPRESS_COUNT, 0);

        // Asynchronous reset mid-press.
        chk("pre_reset_y", oY_SCR, 479);
        #2 iRST_n = 1'b0;
        iTOUCH = 1'b0;
        #1;
        chk("arst_touching", oTOUCHING, 0);
        chk("arst_y", oY_SCR, 0);
        chk("arst_count", oPRESS_COUNT, 0);
        chk("arst_press", oPRESS, 0);
        cyc(2);
        iRST_n = 1'b1;
        cyc(10);
        chk("arst_no_release", oRELEASE, 0);
        chk("arst_touch_low", oTOUCHING, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
